// File: rtl/polar_clip_pkg.sv
// polar_clip_pkg: default widths and saturation-bound helpers shared by the polar clip datapath
package polar_clip_pkg;
  localparam int A_W_DEF = 25;
  localparam int B_W_DEF = 9;
  localparam int DOUT_W_DEF = 25;
  localparam int SHIFT_DEF = 8;
  localparam int NUM_STAGE_DEF = 4;
  function automatic logic signed [63:0] sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/polar_clip_valid_pipe.sv
// polar_clip_valid_pipe: ce-advanced valid-tag delay line of DEPTH stages
module polar_clip_valid_pipe #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic din,
  output logic dout
);
  logic [DEPTH-1:0] tags;
  always_ff @(posedge clk)
    if (reset) tags <= '0;
    else if (ce) tags <= {tags[DEPTH-2:0], din};
  assign dout = tags[DEPTH-1];
endmodule

// File: rtl/polar_clip_mulsat_pipe.sv
// polar_clip_mulsat_pipe: pipelined signed x unsigned multiply, shift, saturate with sticky flag.
// Define POLAR_CLIP_MULSAT_ROUND_EN to round half toward +inf instead of flooring.
module polar_clip_mulsat_pipe
  import polar_clip_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int B_W = B_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int NUM_STAGE = NUM_STAGE_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce,
  input  logic                     in_valid,
  input  logic signed [A_W-1:0]    din0,
  input  logic        [B_W-1:0]    din1,
  input  logic                     sat_clr,
  output logic                     out_valid,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     sat_flag,
  output logic                     sat_sticky
);
  localparam int P_W = A_W + B_W + 1;
  localparam int ND = NUM_STAGE - 2;
`ifdef POLAR_CLIP_MULSAT_ROUND_EN
  localparam logic signed [P_W-1:0] RND = SHIFT > 0 ? P_W'(1) << (SHIFT > 0 ? SHIFT - 1 : 0) : '0;
`else
  localparam logic signed [P_W-1:0] RND = '0;
`endif
  logic signed [A_W-1:0] a_r;
  logic [B_W-1:0] b_r;
  logic signed [P_W-1:0] d [ND];
  logic signed [P_W-1:0] rnd_c, shifted;
  logic signed [63:0] sh64;
  logic hi_c, lo_c, load_v;
  always_ff @(posedge clk)
    if (ce) begin
      a_r <= din0;
      b_r <= din1;
      d[0] <= P_W'(a_r) * P_W'($signed({1'b0, b_r}));
      for (int i = 1; i < ND; i++) d[i] <= d[i-1];
    end
  always_comb begin
    rnd_c = d[ND-1] + RND;
    shifted = rnd_c >>> SHIFT;
    sh64 = 64'(shifted);
    hi_c = sh64 > sat_hi(DOUT_W);
    lo_c = sh64 < sat_lo(DOUT_W);
  end
  polar_clip_valid_pipe #(.DEPTH(NUM_STAGE - 1)) u_vpipe (
    .clk(clk), .reset(reset), .ce(ce), .din(in_valid), .dout(load_v)
  );
  // bubbles advance out_valid but leave the last result and its flag in place
  always_ff @(posedge clk)
    if (reset) begin
      out_valid <= 1'b0;
      dout <= '0;
      sat_flag <= 1'b0;
    end else if (ce) begin
      out_valid <= load_v;
      if (load_v) begin
        dout <= hi_c ? DOUT_W'(sat_hi(DOUT_W)) : lo_c ? DOUT_W'(sat_lo(DOUT_W)) : DOUT_W'(sh64);
        sat_flag <= hi_c | lo_c;
      end
    end
  always_ff @(posedge clk)
    if (reset) sat_sticky <= 1'b0;
    else if (ce && load_v && (hi_c || lo_c)) sat_sticky <= 1'b1;
    else if (sat_clr) sat_sticky <= 1'b0;
endmodule

// File: tb/tb_polar_clip_mulsat_pipe.sv
// tb_polar_clip_mulsat_pipe: directed and random stimulus against a per-sample arithmetic model
module tb_polar_clip_mulsat_pipe;
  localparam int A_W = 25, B_W = 9, DOUT_W = 25, SHIFT = 8, NUM_STAGE = 4;
  typedef struct { bit v; longint d; bit s; } ent_t;
  logic clk = 1'b0, reset = 1'b0, ce = 1'b0, in_valid = 1'b0, sat_clr = 1'b0;
  logic signed [A_W-1:0] din0 = '0;
  logic [B_W-1:0] din1 = '0;
  logic out_valid, sat_flag, sat_sticky;
  logic signed [DOUT_W-1:0] dout;
  int checks = 0, errors = 0, nvalid = 0;
  ent_t hist[$];
  bit m_ov = 0, m_sf = 0, m_st = 0;
  longint m_dout = 0;

  polar_clip_mulsat_pipe #(.A_W(A_W), .B_W(B_W), .DOUT_W(DOUT_W), .SHIFT(SHIFT), .NUM_STAGE(NUM_STAGE)) dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .sat_clr(sat_clr), .out_valid(out_valid), .dout(dout), .sat_flag(sat_flag), .sat_sticky(sat_sticky)
  );
  always #5 clk = ~clk;

  function automatic ent_t ref_calc(input bit v, input logic signed [A_W-1:0] a, input logic [B_W-1:0] b);
    ent_t e;
    longint p, hi, lo;
    p = longint'(a) * longint'({1'b0, b});
`ifdef POLAR_CLIP_MULSAT_ROUND_EN
    if (SHIFT > 0) p = p + (longint'(1) << (SHIFT - 1));
`endif
    p = p >>> SHIFT;
    hi = (longint'(1) << (DOUT_W - 1)) - 1;
    lo = -hi - 1;
    e.v = v;
    e.s = (p > hi) || (p < lo);
    e.d = p > hi ? hi : p < lo ? lo : p;
    return e;
  endfunction

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input bit c, input bit v, input logic signed [A_W-1:0] a, input logic [B_W-1:0] b,
                      input bit clr, input bit rst);
    ent_t e;
    bit loaded;
    ce = c; in_valid = v; din0 = a; din1 = b; sat_clr = clr; reset = rst;
    @(posedge clk);
    loaded = 0;
    if (rst) begin
      hist.delete();
      m_ov = 0; m_dout = 0; m_sf = 0; m_st = 0;
    end else begin
      if (c) begin
        hist.push_back(ref_calc(v, a, b));
        if (hist.size() > NUM_STAGE) void'(hist.pop_front());
        m_ov = 0;
        if (hist.size() == NUM_STAGE) begin
          e = hist[0];
          m_ov = e.v;
          if (e.v) begin
            m_dout = e.d; m_sf = e.s; loaded = e.s;
          end
        end
      end
      if (loaded) m_st = 1;
      else if (clr) m_st = 0;
    end
    #1;
    if (out_valid === 1'b1) nvalid++;
    chk("out_valid", longint'(out_valid), longint'(m_ov));
    chk("dout", longint'(dout), m_dout);
    chk("sat_flag", longint'(sat_flag), longint'(m_sf));
    chk("sat_sticky", longint'(sat_sticky), longint'(m_st));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, '0, '0, 0, 0);
  endtask

  task automatic rnd_valid();
    step(1, 1, A_W'($urandom), B_W'($urandom), 0, 0);
  endtask

  initial begin
    step(0, 1, 25'sd77, 9'd5, 0, 1);
    step(1, 1, 25'sd77, 9'd5, 0, 1);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_dout", longint'(dout), 0);
    chk("reset_sticky", longint'(sat_sticky), 0);
    // rounding / floor pair
    step(1, 1, 25'sd3, 9'd128, 0, 0);
    idle(3);
`ifdef POLAR_CLIP_MULSAT_ROUND_EN
    chk("round_pos", longint'(dout), 2);
`else
    chk("floor_pos", longint'(dout), 1);
`endif
    chk("pos_valid", longint'(out_valid), 1);
    step(1, 1, -25'sd3, 9'd128, 0, 0);
    idle(3);
`ifdef POLAR_CLIP_MULSAT_ROUND_EN
    chk("round_neg", longint'(dout), -1);
`else
    chk("floor_neg", longint'(dout), -2);
`endif
    // saturation at both rails
    step(1, 1, 25'sd16777215, 9'd511, 0, 0);
    idle(3);
    chk("sat_hi_dout", longint'(dout), 16777215);
    chk("sat_hi_flag", longint'(sat_flag), 1);
    chk("sat_hi_sticky", longint'(sat_sticky), 1);
    step(1, 1, -25'sd16777216, 9'd511, 0, 0);
    idle(3);
    chk("sat_lo_dout", longint'(dout), -16777216);
    chk("sat_lo_flag", longint'(sat_flag), 1);
    step(1, 0, '0, '0, 1, 0);
    chk("sticky_clr", longint'(sat_sticky), 0);
    // stall: ce low holds every stage
    step(1, 1, 25'sd1000, 9'd300, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, '0, '0, 0, 0);
    idle(2);
    chk("stall_not_yet", longint'(out_valid), 0);
    idle(1);
    chk("stall_valid", longint'(out_valid), 1);
    // streaming with one bubble
    idle(4);
    nvalid = 0;
    for (int i = 0; i < 8; i++) rnd_valid();
    idle(1);
    for (int i = 0; i < 4; i++) rnd_valid();
    idle(4);
    chk("stream_count", longint'(nvalid), 12);
    // reset with samples in flight
    for (int i = 0; i < 3; i++) rnd_valid();
    step(1, 0, '0, '0, 0, 1);
    nvalid = 0;
    rnd_valid();
    idle(2);
    chk("post_reset_quiet", longint'(nvalid), 0);
    idle(1);
    chk("post_reset_valid", longint'(out_valid), 1);
    // sticky set wins over simultaneous clear
    step(1, 1, 25'sd16777215, 9'd511, 0, 0);
    idle(2);
    step(1, 0, '0, '0, 1, 0);
    chk("sticky_set_wins", longint'(sat_sticky), 1);
    step(1, 0, '0, '0, 1, 0);
    chk("sticky_then_clr", longint'(sat_sticky), 0);
    // random mix
    for (int i = 0; i < 400; i++) begin
      logic signed [A_W-1:0] a;
      logic [B_W-1:0] b;
      a = A_W'($urandom);
      b = B_W'($urandom);
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1) ? 25'sd16777215 : -25'sd16777216;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, a, b,
           $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
